// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the MIPS-subset datapath (shared ALU, unified memory port).
// Optional retired-instruction counter on port instr_count when MC_PERF_CNT_EN is defined.
module controle_multiciclo #(
   parameter int OPW  = 6,
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OPW-1:0]  opcode,
   input  logic            mem_ready,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            BranchNe,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            MemToReg,
   output logic            RegDst,
   output logic            RegWrite,
   output logic            WriteLink,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [3:0]      ALUOp,
   output logic [1:0]      PCSource,
   output logic            illegal,
`ifdef MC_PERF_CNT_EN
   output logic [31:0]     instr_count,
`endif
   output logic [ST_W-1:0] state
);

   typedef enum logic [ST_W-1:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC_R = 4'd7,
      S_WB_R   = 4'd8,
      S_EXEC_I = 4'd9,
      S_WB_I   = 4'd10,
      S_BRANCH = 4'd11,
      S_JUMP   = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPW-1:0] OP_J     = 6'b000010;
   localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OPW-1:0] OP_SLTIU = 6'b001011;
   localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
   localparam logic [OPW-1:0] OP_XORI  = 6'b001110;
   localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
   localparam logic [OPW-1:0] OP_LW    = 6'b100011;
   localparam logic [OPW-1:0] OP_SW    = 6'b101011;

   state_t state_r;
   state_t next_s;

   // State register; rst forces RESET without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_RESET;
      end else begin
         state_r <= next_s;
      end
   end

   assign state = state_r;

   // Next-state and Moore output decode; only FETCH looks at mem_ready for its outputs.
   always_comb begin
      next_s      = S_FETCH;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      WriteLink   = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 4'b0000;
      PCSource    = 2'b00;
      illegal     = 1'b0;
      case (state_r)
         S_RESET: begin
            next_s = S_FETCH;
         end
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               next_s = S_DECODE;
            end else begin
               next_s = S_FETCH;
            end
         end
         S_DECODE: begin
            // Speculative branch target goes into ALUOut while the opcode is decoded.
            ALUSrcB = 2'b11;
            case (opcode)
               OP_LW, OP_SW:   next_s = S_MEMADR;
               OP_RTYPE:       next_s = S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
               OP_SLTI, OP_SLTIU, OP_LUI:
                               next_s = S_EXEC_I;
               OP_BEQ, OP_BNE: next_s = S_BRANCH;
               OP_J, OP_JAL:   next_s = S_JUMP;
               default:        next_s = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_LW:   next_s = S_MEMRD;
               OP_SW:   next_s = S_MEMWR;
               default: next_s = S_TRAP;
            endcase
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               next_s = S_MEMWB;
            end else begin
               next_s = S_MEMRD;
            end
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
            next_s   = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               next_s = S_FETCH;
            end else begin
               next_s = S_MEMWR;
            end
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 4'b1111;
            next_s  = S_WB_R;
         end
         S_WB_R: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            next_s   = S_FETCH;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_ANDI:  ALUOp = 4'b0101;
               OP_ORI:   ALUOp = 4'b0110;
               OP_XORI:  ALUOp = 4'b0111;
               OP_SLTI:  ALUOp = 4'b0011;
               OP_SLTIU: ALUOp = 4'b0100;
               OP_LUI:   ALUOp = 4'b1000;
               default:  ALUOp = 4'b0000;
            endcase
            next_s = S_WB_I;
         end
         S_WB_I: begin
            RegWrite = 1'b1;
            next_s   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            if (opcode == OP_BNE) begin
               ALUOp    = 4'b0010;
               BranchNe = 1'b1;
            end else begin
               ALUOp    = 4'b0001;
               BranchNe = 1'b0;
            end
            next_s = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            if (opcode == OP_JAL) begin
               RegWrite  = 1'b1;
               WriteLink = 1'b1;
            end else begin
               RegWrite  = 1'b0;
               WriteLink = 1'b0;
            end
            next_s = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
            next_s  = S_TRAP;
         end
         default: begin
            next_s = S_FETCH;
         end
      endcase
   end

`ifdef MC_PERF_CNT_EN
   logic [31:0] instr_count_r;

   // Counts completed fetches; wraps naturally and cannot advance once trapped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count_r <= 32'd0;
      end else if ((state_r == S_FETCH) && mem_ready) begin
         instr_count_r <= instr_count_r + 32'd1;
      end else begin
         instr_count_r <= instr_count_r;
      end
   end

   assign instr_count = instr_count_r;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Table-driven bench for controle_multiciclo plus directed stall, reset, trap and counter sequences.
module tb_controle_multiciclo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'b000000;
   logic       mem_ready = 1'b1;
   logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
   logic       MemToReg, RegDst, RegWrite, WriteLink, ALUSrcA, illegal;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUOp, state;
`ifdef MC_PERF_CNT_EN
   logic [31:0] instr_count;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   controle_multiciclo dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .WriteLink(WriteLink), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSource(PCSource), .illegal(illegal),
`ifdef MC_PERF_CNT_EN
      .instr_count(instr_count),
`endif
      .state(state)
   );

   logic [20:0] ctl_s;
   assign ctl_s = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                   MemToReg, RegDst, RegWrite, WriteLink, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, illegal};

   function automatic logic [20:0] mk(input logic pcw, pcwc, bne, iord, mr, mw, irw,
                                      m2r, rd, rw, wl, asa, input logic [1:0] asb,
                                      input logic [3:0] aop, input logic [1:0] pcs,
                                      input logic ill);
      return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, wl, asa, asb, aop, pcs, ill};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      logic [5:0]  op;
      int          ncyc;
      logic [15:0] seq;
      int          keyk;
      logic [20:0] kexp;
   } vec_t;

   vec_t vt[14];

   logic [20:0] fetch_exp, decode_exp, zero_exp;
   int irw, mw, rw, bad;
   logic [3:0] exp_st;

   initial begin
      fetch_exp  = mk(1,0,0,0,1,0,1,0,0,0,0,0,2'b01,4'b0000,2'b00,0);
      decode_exp = mk(0,0,0,0,0,0,0,0,0,0,0,0,2'b11,4'b0000,2'b00,0);
      zero_exp   = 21'd0;

      vt[0]  = '{"LW",    6'b100011, 5, 16'h2345, 4, mk(0,0,0,0,0,0,0,1,0,1,0,0,2'b00,4'b0000,2'b00,0)};
      vt[1]  = '{"SW",    6'b101011, 4, 16'h2360, 3, mk(0,0,0,1,0,1,0,0,0,0,0,0,2'b00,4'b0000,2'b00,0)};
      vt[2]  = '{"RTYPE", 6'b000000, 4, 16'h2780, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b00,4'b1111,2'b00,0)};
      vt[3]  = '{"ADDI",  6'b001000, 4, 16'h29A0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b0000,2'b00,0)};
      vt[4]  = '{"ANDI",  6'b001100, 4, 16'h29A0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b0101,2'b00,0)};
      vt[5]  = '{"ORI",   6'b001101, 4, 16'h29A0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b0110,2'b00,0)};
      vt[6]  = '{"XORI",  6'b001110, 4, 16'h29A0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b0111,2'b00,0)};
      vt[7]  = '{"SLTI",  6'b001010, 4, 16'h29A0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b0011,2'b00,0)};
      vt[8]  = '{"SLTIU", 6'b001011, 4, 16'h29A0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b0100,2'b00,0)};
      vt[9]  = '{"LUI",   6'b001111, 4, 16'h29A0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b1000,2'b00,0)};
      vt[10] = '{"BEQ",   6'b000100, 3, 16'h2B00, 2, mk(0,1,0,0,0,0,0,0,0,0,0,1,2'b00,4'b0001,2'b01,0)};
      vt[11] = '{"BNE",   6'b000101, 3, 16'h2B00, 2, mk(0,1,1,0,0,0,0,0,0,0,0,1,2'b00,4'b0010,2'b01,0)};
      vt[12] = '{"J",     6'b000010, 3, 16'h2C00, 2, mk(1,0,0,0,0,0,0,0,0,0,0,0,2'b00,4'b0000,2'b10,0)};
      vt[13] = '{"JAL",   6'b000011, 3, 16'h2C00, 2, mk(1,0,0,0,0,0,0,0,0,1,1,0,2'b00,4'b0000,2'b10,0)};

      // Reset state while rst is held, then one cycle of RESET after release.
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_outputs", 32'(ctl_s), 32'(zero_exp));
      tick();
      tick();
      rst = 1'b0;
      chk("post_rst_state", 32'(state), 32'd0);
      tick();
      chk("first_fetch", 32'(state), 32'd1);

      // Table: one full instruction per record with mem_ready held high.
      for (int i = 0; i < 14; i++) begin
         opcode    = vt[i].op;
         mem_ready = 1'b1;
         irw       = 0;
         for (int k = 0; k < vt[i].ncyc; k++) begin
            #1;
            if (k == 0) begin
               chk({vt[i].name, "_fetch_state"}, 32'(state), 32'd1);
               chk({vt[i].name, "_fetch_ctl"}, 32'(ctl_s), 32'(fetch_exp));
            end else begin
               exp_st = 4'(vt[i].seq >> (4 * (4 - k)));
               chk({vt[i].name, "_seq"}, 32'(state), 32'(exp_st));
            end
            if (k == 1) chk({vt[i].name, "_decode_ctl"}, 32'(ctl_s), 32'(decode_exp));
            if (k == vt[i].keyk) chk({vt[i].name, "_key_ctl"}, 32'(ctl_s), 32'(vt[i].kexp));
            irw += int'(IRWrite);
            tick();
         end
         chk({vt[i].name, "_cpi_back_to_fetch"}, 32'(state), 32'd1);
         chk({vt[i].name, "_irwrite_once"}, 32'(irw), 32'd1);
      end

      // LW with one FETCH stall and one MEMRD stall.
      opcode    = 6'b100011;
      mem_ready = 1'b0;
      #1;
      chk("fetch_stall_ctl", 32'(ctl_s), 32'(mk(0,0,0,0,1,0,0,0,0,0,0,0,2'b01,4'b0000,2'b00,0)));
      tick();
      chk("fetch_stall_hold", 32'(state), 32'd1);
      mem_ready = 1'b1;
      #1;
      chk("fetch_ready_irw", 32'(IRWrite), 32'd1);
      tick();
      tick();
      chk("memadr_ctl", 32'(ctl_s), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,1,2'b10,4'b0000,2'b00,0)));
      tick();
      mem_ready = 1'b0;
      #1;
      chk("memrd_ctl", 32'(ctl_s), 32'(mk(0,0,0,1,1,0,0,0,0,0,0,0,2'b00,4'b0000,2'b00,0)));
      tick();
      chk("memrd_hold", 32'(state), 32'd4);
      mem_ready = 1'b1;
      tick();
      chk("memrd_to_memwb", 32'(state), 32'd5);
      tick();
      chk("lw_stall_done", 32'(state), 32'd1);

      // SW with mem_ready low for two MEMWR cycles.
      opcode = 6'b101011;
      tick();
      tick();
      tick();
      chk("sw_in_memwr", 32'(state), 32'd6);
      mem_ready = 1'b0;
      mw = 0; rw = 0; bad = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) mem_ready = 1'b1;
         #1;
         mw += int'(MemWrite);
         rw += int'(RegWrite);
         if (IorD !== 1'b1) bad++;
         tick();
      end
      chk("sw_memwrite_cycles", 32'(mw), 32'd3);
      chk("sw_regwrite_zero", 32'(rw), 32'd0);
      chk("sw_iord_held", 32'(bad), 32'd0);
      chk("sw_back_to_fetch", 32'(state), 32'd1);

      // Reset during a stalled MEMWR aborts the write immediately.
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      #1;
      chk("abort_memwrite_before", 32'(MemWrite), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_memwrite_after", 32'(MemWrite), 32'd0);
      chk("abort_state", 32'(state), 32'd0);
      tick();
      mem_ready = 1'b1;
      rst = 1'b0;
      chk("abort_reset_state", 32'(state), 32'd0);
      tick();
      chk("abort_then_fetch", 32'(state), 32'd1);

      // Unlisted opcode 001001 traps.
      opcode = 6'b001001;
      tick();
      tick();
      chk("trap_addiu", 32'(state), 32'd13);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Opcode 111111: trap is absorbing, reset exits without a clock edge.
      opcode = 6'b111111;
      tick();
      tick();
      chk("trap_state", 32'(state), 32'd13);
      chk("trap_ctl", 32'(ctl_s), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,0,2'b00,4'b0000,2'b00,1)));
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (state !== 4'd13 || illegal !== 1'b1) bad++;
         tick();
      end
      chk("trap_held_20", 32'(bad), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("trap_rst_illegal", 32'(illegal), 32'd0);
      chk("trap_rst_state", 32'(state), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("trap_recover_fetch", 32'(state), 32'd1);

`ifdef MC_PERF_CNT_EN
      chk("cnt_after_rst", instr_count, 32'd0);
      mem_ready = 1'b0;
      tick();
      mem_ready = 1'b1;
      opcode = 6'b000000;
      for (int c = 0; c < 4; c++) tick();
      opcode = 6'b000010;
      for (int c = 0; c < 3; c++) tick();
      opcode = 6'b000100;
      for (int c = 0; c < 3; c++) tick();
      chk("cnt_three", instr_count, 32'd3);
      opcode = 6'b000010;
      tick();
      force dut.instr_count_r = 32'hFFFF_FFFF;
      #1;
      release dut.instr_count_r;
      tick();
      tick();
      chk("cnt_preload", instr_count, 32'hFFFF_FFFF);
      tick();
      chk("cnt_wrap", instr_count, 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
